// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared helpers for the async FIFO pointer logic.
//   PTR_MAX     widest pointer the helpers handle; callers zero-extend into it
//   fifo_depth  DEPTH = 1 << ADDRSIZE
//   bin2gray    binary -> Gray, width-generic for zero-extended inputs
//   gray2bin    Gray -> binary (XOR prefix from the MSB), width-generic for
//               zero-extended inputs; the caller keeps its low ADDRSIZE+1 bits
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int PTR_MAX = 32;

  function automatic int fifo_depth(input int addrsize);
    return int'(32'd1 << addrsize);
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] ptr);
    return (ptr >> 1) ^ ptr;
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] ptr);
    logic [PTR_MAX-1:0] bin;
    bin[PTR_MAX-1] = ptr[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ ptr[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin_conv #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin = {WIDTH{1'b0}};
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/wptr_full_level.sv
// -----------------------------------------------------------------------------
// wptr_full_level
// Write-domain pointer and status generator of the async FIFO. Keeps binary
// and Gray write pointers, drives the RAM write address and produces
// registered full, almost-full, fill-level and overflow indications.
// Optional feature macro: WPTR_OVF_STICKY_EN adds a latched overflow flag
// (wovf_sticky) with its clear input (wovf_clr).
// Ports:
//   wclk          in   1           write clock
//   wrst_n        in   1           asynchronous active-low reset
//   winc          in   1           write request, accepted only while not full
//   wq2_rptr      in   ADDRSIZE+1  synchronized read Gray pointer
//   waddr         out  ADDRSIZE    RAM write address
//   wptr          out  ADDRSIZE+1  registered Gray write pointer
//   wfull         out  1           registered full flag
//   walmost_full  out  1           registered level >= AFULL_THRESH
//   wlevel        out  ADDRSIZE+1  registered fill level, 0..DEPTH
//   wovf          out  1           one-cycle pulse for a dropped write
//   wovf_clr      in   1           [WPTR_OVF_STICKY_EN] clears wovf_sticky
//   wovf_sticky   out  1           [WPTR_OVF_STICKY_EN] latched overflow
// -----------------------------------------------------------------------------
module wptr_full_level
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
`ifdef WPTR_OVF_STICKY_EN
  ,
  input  logic                wovf_clr,
  output logic                wovf_sticky
`endif
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

  // Reject an almost-full threshold outside 1..DEPTH at elaboration.
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("wptr_full_level: AFULL_THRESH out of range 1..DEPTH");
  end

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic          wfull_r;
  logic          walmost_full_r;
  logic [PW-1:0] wlevel_r;
  logic          wovf_r;

  logic          winc_ok_s;
  logic          ovf_set_s;
  logic [PW-1:0] wbinnext_s;
  logic [PW-1:0] wgraynext_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] lvl_next_s;
  logic [PTR_MAX-1:0] gray_wide_s;

  // Read pointer back to binary so the level is a plain subtraction.
  gray2bin_conv #(.WIDTH(PW)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  // Next-state pointer, level and overflow terms.
  always_comb begin
    winc_ok_s   = winc & ~wfull_r;
    ovf_set_s   = winc & wfull_r;
    wbinnext_s  = wbin_r + {{ADDRSIZE{1'b0}}, winc_ok_s};
    gray_wide_s = bin2gray({{(PTR_MAX-PW){1'b0}}, wbinnext_s});
    wgraynext_s = gray_wide_s[PW-1:0];
    // Modulo subtraction absorbs the wrap of either pointer; a stale
    // read pointer can only make this larger, never smaller.
    lvl_next_s  = wbinnext_s - rbin_s;
  end

  // Pointer, level and flag registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r         <= {PW{1'b0}};
      wptr_r         <= {PW{1'b0}};
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= {PW{1'b0}};
      wovf_r         <= 1'b0;
    end else begin
      wbin_r         <= wbinnext_s;
      wptr_r         <= wgraynext_s;
      wfull_r        <= (lvl_next_s == DEPTH_P);
      walmost_full_r <= (lvl_next_s >= AFULL_P);
      wlevel_r       <= lvl_next_s;
      wovf_r         <= ovf_set_s;
    end
  end

`ifdef WPTR_OVF_STICKY_EN
  logic wovf_sticky_r;

  // Latched overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_sticky_r <= 1'b0;
    end else begin
      wovf_sticky_r <= ovf_set_s | (wovf_sticky_r & ~wovf_clr);
    end
  end

  assign wovf_sticky = wovf_sticky_r;
`endif

  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wptr         = wptr_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign wovf         = wovf_r;

endmodule

// File: tb/tb_wptr_full_level.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_level
// Directed bench for wptr_full_level with ADDRSIZE=4, AFULL_THRESH=12.
// Define WPTR_OVF_STICKY_EN for the build to include the sticky-flag checks.
// -----------------------------------------------------------------------------
module tb_wptr_full_level;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;
`ifdef WPTR_OVF_STICKY_EN
  logic       wovf_clr;
  logic       wovf_sticky;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_bin;

  wptr_full_level #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
`ifdef WPTR_OVF_STICKY_EN
    ,
    .wovf_clr     (wovf_clr),
    .wovf_sticky  (wovf_sticky)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".waddr"},  32'(waddr),        32'd0);
    check_eq({tag, ".wptr"},   32'(wptr),         32'd0);
    check_eq({tag, ".wfull"},  32'(wfull),        32'd0);
    check_eq({tag, ".afull"},  32'(walmost_full), 32'd0);
    check_eq({tag, ".wlevel"}, 32'(wlevel),       32'd0);
    check_eq({tag, ".wovf"},   32'(wovf),         32'd0);
`ifdef WPTR_OVF_STICKY_EN
    check_eq({tag, ".sticky"}, 32'(wovf_sticky),  32'd0);
`endif
  endtask

  initial begin
    wrst_n   = 1'b1;
    winc     = 1'b0;
    wq2_rptr = 5'd0;
`ifdef WPTR_OVF_STICKY_EN
    wovf_clr = 1'b0;
`endif

    // 1. async reset takes effect without a clock edge
    #2 wrst_n = 1'b0;
    #1 check_zero("rst_assert");
    tick();
    tick();
    wrst_n = 1'b1;
    tick();
    tick();
    check_zero("rst_release");

    // 2. fill to full with the read pointer parked at 0
    for (int k = 1; k <= 16; k++) begin
      winc = 1'b1;
      check_eq("fill.waddr", 32'(waddr), 32'(k - 1));
      tick();
      check_eq("fill.wlevel", 32'(wlevel), 32'(k));
      check_eq("fill.afull", 32'(walmost_full), (k >= 12) ? 32'd1 : 32'd0);
      check_eq("fill.wfull", 32'(wfull), (k == 16) ? 32'd1 : 32'd0);
    end
    check_eq("full.wptr", 32'(wptr), 32'b11000);

    // 3. writes while full are dropped and flagged
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("ovf.wovf", 32'(wovf), 32'd1);
      check_eq("ovf.wptr", 32'(wptr), 32'b11000);
      check_eq("ovf.waddr", 32'(waddr), 32'd0);
      check_eq("ovf.wlevel", 32'(wlevel), 32'd16);
      check_eq("ovf.wfull", 32'(wfull), 32'd1);
    end
    winc = 1'b0;
    tick();
    check_eq("ovf_end.wovf", 32'(wovf), 32'd0);
`ifdef WPTR_OVF_STICKY_EN
    check_eq("sticky.hold", 32'(wovf_sticky), 32'd1);
    wovf_clr = 1'b1;
    tick();
    wovf_clr = 1'b0;
    check_eq("sticky.clr", 32'(wovf_sticky), 32'd0);
    winc = 1'b1;
    wovf_clr = 1'b1;
    tick();
    check_eq("sticky.setwins", 32'(wovf_sticky), 32'd1);
    check_eq("sticky.wovf", 32'(wovf), 32'd1);
    winc = 1'b0;
    tick();
    wovf_clr = 1'b0;
    check_eq("sticky.clr2", 32'(wovf_sticky), 32'd0);
`endif

    // 4. read pointer advances out of full
    wq2_rptr = 5'b00110;
    tick();
    check_eq("rd4.wfull", 32'(wfull), 32'd0);
    check_eq("rd4.wlevel", 32'(wlevel), 32'd12);
    check_eq("rd4.afull", 32'(walmost_full), 32'd1);
    wq2_rptr = 5'b00111;
    tick();
    check_eq("rd5.wlevel", 32'(wlevel), 32'd11);
    check_eq("rd5.afull", 32'(walmost_full), 32'd0);

    // 5. streaming with the reader 3 behind, crossing the pointer wrap
    exp_bin = 5'd16;
    for (int k = 0; k < 40; k++) begin
      wq2_rptr = to_gray(exp_bin - 5'd3);
      winc = 1'b1;
      tick();
      exp_bin = exp_bin + 5'd1;
      check_eq("stream.wlevel", 32'(wlevel), 32'd4);
      check_eq("stream.wfull", 32'(wfull), 32'd0);
      check_eq("stream.wptr", 32'(wptr), 32'(to_gray(exp_bin)));
      check_eq("stream.waddr", 32'(waddr), 32'(exp_bin[3:0]));
    end
    winc = 1'b0;
    wq2_rptr = to_gray(exp_bin - 5'd3);
    tick();
    check_eq("stream_end.wlevel", 32'(wlevel), 32'd3);
    check_eq("stream_end.wptr", 32'(wptr), 32'b10100);

    // 6. async reset in the middle of a burst
    winc = 1'b1;
    tick();
    tick();
    tick();
    check_eq("burst.wlevel", 32'(wlevel), 32'd6);
    #2 wrst_n = 1'b0;
    #1 check_zero("rst_mid");
    winc = 1'b0;
    wq2_rptr = 5'd0;
    tick();
    wrst_n = 1'b1;
    tick();
    check_zero("rst_mid_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
